mem_port_arbiter: RTL and testbench

Shares the single PDP-8 memory port between the CPU and a data-break (DMA) channel.
- Each requester posts a one-word read or write. The block grants one requester, drives the memory strobes, waits out the fixed memory latency, and returns read data with a done pulse.
- Sits between the CPU/data-break masters and the memory module.
- Data break has priority; a starvation guard is optional.

---
 rtl/mem_port_arbiter_pkg.sv | 7 +
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter_dma_streak_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared arbiter state, owner encodings and latency limits
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_COMPLETE} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_CPU = 2'b01, OWN_DMA = 2'b10} owner_t;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_W = $clog2(MEM_LAT_MAX + 1);
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, memory and status signals of the shared memory port
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_done;
  logic [DATA_W-1:0] dma_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;
  owner_t            owner;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_read_data,
    output cpu_gnt, cpu_done, cpu_rdata,
    output dma_gnt, dma_done, dma_rdata,
    output mem_address, mem_write_data, mem_read_enable, mem_write_enable,
    output busy, owner
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_read_data,
    input  cpu_gnt, cpu_done, cpu_rdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_address, mem_write_data, mem_read_enable, mem_write_enable,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter_dma_streak_counter.sv
// dma_streak_counter: counts DMA grants won over a waiting CPU; only built with ARB_STARVE_GUARD_EN
`ifdef ARB_STARVE_GUARD_EN
module dma_streak_counter #(
  parameter int MAX_DMA_STREAK = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_i,
  input  logic cpu_req_i,
  input  logic cpu_win_i,
  input  logic dma_win_i,
  output logic at_max_o
);
  localparam int W = $clog2(MAX_DMA_STREAK + 1);
  logic [W-1:0] streak_q, streak_d;
  // clear when the CPU is served or not waiting; count DMA wins that made the CPU wait
  always_comb begin
    streak_d = (cpu_win_i || (arb_i && !cpu_req_i)) ? '0 :
               (dma_win_i && streak_q != W'(MAX_DMA_STREAK)) ? streak_q + 1'b1 : streak_q;
  end
  // streak register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) streak_q <= '0;
    else       streak_q <= streak_d;
  end
  assign at_max_o = streak_q == W'(MAX_DMA_STREAK);
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the memory port between CPU and data break; ARB_STARVE_GUARD_EN enables the CPU starvation guard
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 12,
  parameter int MEM_LAT        = 1,
  parameter int MAX_DMA_STREAK = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX || MAX_DMA_STREAK < 1) begin : g_bad_param
    $error("mem_port_arbiter: illegal MEM_LAT or MAX_DMA_STREAK");
  end
  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dma_done_q, dma_done_d;
  logic              re_q, re_d;
  logic              wre_q, wre_d;
  logic              busy_q, busy_d;
  logic              arb, cpu_win, dma_win, guard_hit;
  assign arb     = state_q == ARB_IDLE || state_q == ARB_COMPLETE;
  assign cpu_win = arb && bus.cpu_req && (!bus.dma_req || guard_hit);
  assign dma_win = arb && bus.dma_req && !cpu_win;
`ifdef ARB_STARVE_GUARD_EN
  dma_streak_counter #(.MAX_DMA_STREAK(MAX_DMA_STREAK)) u_streak (
    .clock     (clock),
    .reset     (reset),
    .arb_i     (arb),
    .cpu_req_i (bus.cpu_req),
    .cpu_win_i (cpu_win),
    .dma_win_i (dma_win),
    .at_max_o  (guard_hit)
  );
`else
  assign guard_hit = 1'b0;
`endif
  // next state: arbitrate in IDLE/COMPLETE, strobe in ISSUE, count latency in WAIT
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_gnt_d   = 1'b0;
    dma_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    dma_done_d  = 1'b0;
    re_d        = 1'b0;
    wre_d       = 1'b0;
    if (arb) begin
      state_d = (cpu_win || dma_win) ? ARB_ISSUE : ARB_IDLE;
      owner_d = cpu_win ? OWN_CPU : dma_win ? OWN_DMA : OWN_NONE;
      if (cpu_win || dma_win) begin
        we_d      = cpu_win ? bus.cpu_we : bus.dma_we;
        addr_d    = cpu_win ? bus.cpu_addr : bus.dma_addr;
        wdata_d   = cpu_win ? bus.cpu_wdata : bus.dma_wdata;
        cpu_gnt_d = cpu_win;
        dma_gnt_d = dma_win;
        re_d      = !we_d;
        wre_d     = we_d;
      end
    end else if (state_q == ARB_ISSUE) begin
      state_d = ARB_WAIT;
      cnt_d   = LAT_W'(MEM_LAT - 1);
    end else if (cnt_q == '0) begin
      state_d     = ARB_COMPLETE;
      cpu_done_d  = owner_q == OWN_CPU;
      dma_done_d  = owner_q == OWN_DMA;
      cpu_rdata_d = (owner_q == OWN_CPU && !we_q) ? bus.mem_read_data : cpu_rdata_q;
      dma_rdata_d = (owner_q == OWN_DMA && !we_q) ? bus.mem_read_data : dma_rdata_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    busy_d = state_d != ARB_IDLE;
  end
  // state and registered outputs; reset abandons any access in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      re_q        <= 1'b0;
      wre_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      re_q        <= re_d;
      wre_q       <= wre_d;
      busy_q      <= busy_d;
    end
  end
  assign bus.cpu_gnt          = cpu_gnt_q;
  assign bus.cpu_done         = cpu_done_q;
  assign bus.cpu_rdata        = cpu_rdata_q;
  assign bus.dma_gnt          = dma_gnt_q;
  assign bus.dma_done         = dma_done_q;
  assign bus.dma_rdata        = dma_rdata_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.mem_read_enable  = re_q;
  assign bus.mem_write_enable = wre_q;
  assign bus.busy             = busy_q;
  assign bus.owner            = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_mem_port_arbiter;
  typedef struct {
    int         port;
    logic [11:0] rdata;
    int         cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [11:0] mem1 [4096];
  int   cnt1 = 0;
  int   cnt3 = 0;
  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(12)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(12)) b3 ();
  mem_port_arbiter #(.ADDR_W(12), .DATA_W(12), .MEM_LAT(1), .MAX_DMA_STREAK(4)) d1 (
    .clock(clk), .reset(rst), .bus(b1));
  mem_port_arbiter #(.ADDR_W(12), .DATA_W(12), .MEM_LAT(3), .MAX_DMA_STREAK(4)) d3 (
    .clock(clk), .reset(rst), .bus(b3));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // memory models: data is valid only MEM_LAT cycles after the strobe, junk otherwise
  always @(posedge clk) begin
    cnt1 <= b1.mem_read_enable ? 1 : cnt1 + 1;
    cnt3 <= b3.mem_read_enable ? 1 : cnt3 + 1;
    if (rst) mem1[12'o0200] <= 12'o7402;
    else if (b1.mem_write_enable) mem1[b1.mem_address] <= b1.mem_write_data;
  end
  assign b1.mem_read_data = (cnt1 == 1) ? mem1[b1.mem_address] : 12'(12'o6000 + cnt1);
  assign b3.mem_read_data = (cnt3 == 3) ? 12'o5252 : 12'(12'o0100 + cnt3);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic observe(input int port, input logic [11:0] rd);
    exp_t e;
    chk("sb_has_entry", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("done_port", port, e.port);
      chk("done_rdata", rd, e.rdata);
      chk("done_cycle", cyc, e.cyc);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (b1.cpu_done) observe(0, b1.cpu_rdata);
    if (b1.dma_done) observe(1, b1.dma_rdata);
    if (b3.cpu_done) observe(2, b3.cpu_rdata);
  end
  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c;
    int cpu_k;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = 0; b1.dma_wdata = 0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0;
    b3.dma_req = 0; b3.dma_we = 0; b3.dma_addr = 0; b3.dma_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", b1.busy, 0);
    chk("rst_owner", b1.owner, 0);
    chk("rst_strobes", {b1.mem_read_enable, b1.mem_write_enable}, 0);
    chk("rst_addr", b1.mem_address, 0);
    chk("rst_gnt", {b1.cpu_gnt, b1.dma_gnt, b1.cpu_done, b1.dma_done}, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    // single CPU read of 0200
    c = cyc;
    sb.push_back('{0, 12'o7402, c + 3});
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 12'o0200;
    @(negedge clk);
    chk("t1_cpu_gnt", b1.cpu_gnt, 1);
    chk("t1_dma_gnt", b1.dma_gnt, 0);
    chk("t1_re", b1.mem_read_enable, 1);
    chk("t1_we", b1.mem_write_enable, 0);
    chk("t1_addr", b1.mem_address, 12'o0200);
    chk("t1_owner", b1.owner, 2'b01);
    chk("t1_busy", b1.busy, 1);
    b1.cpu_req = 0;
    @(negedge clk);
    chk("t1_wait_gnt", b1.cpu_gnt, 0);
    chk("t1_wait_re", b1.mem_read_enable, 0);
    chk("t1_wait_owner", b1.owner, 2'b01);
    chk("t1_wait_done", b1.cpu_done, 0);
    @(negedge clk);
    chk("t1_cmp_owner", b1.owner, 2'b01);
    @(negedge clk);
    chk("t1_idle_owner", b1.owner, 0);
    chk("t1_idle_busy", b1.busy, 0);
    chk("t1_done_pulse", b1.cpu_done, 0);
    chk("t1_rdata_hold", b1.cpu_rdata, 12'o7402);
    // DMA write 1234 to 0010
    c = cyc;
    sb.push_back('{1, 12'o0000, c + 3});
    b1.dma_req = 1; b1.dma_we = 1; b1.dma_addr = 12'o0010; b1.dma_wdata = 12'o1234;
    @(negedge clk);
    chk("t2_dma_gnt", b1.dma_gnt, 1);
    chk("t2_we", b1.mem_write_enable, 1);
    chk("t2_re", b1.mem_read_enable, 0);
    chk("t2_addr", b1.mem_address, 12'o0010);
    chk("t2_wdata", b1.mem_write_data, 12'o1234);
    chk("t2_owner", b1.owner, 2'b10);
    b1.dma_req = 0;
    @(negedge clk);
    chk("t2_we_one_cycle", b1.mem_write_enable, 0);
    repeat (2) @(negedge clk);
    chk("t2_addr_held", b1.mem_address, 12'o0010);
    chk("t2_mem_written", mem1[12'o0010], 12'o1234);
    // simultaneous requests: DMA read 0010 first, CPU read 0200 from DMA's COMPLETE
    c = cyc;
    sb.push_back('{1, 12'o1234, c + 3});
    sb.push_back('{0, 12'o7402, c + 6});
    b1.dma_req = 1; b1.dma_we = 0; b1.dma_addr = 12'o0010;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 12'o0200;
    @(negedge clk);
    chk("t3_dma_first", b1.dma_gnt, 1);
    chk("t3_cpu_waits", b1.cpu_gnt, 0);
    chk("t3_owner_dma", b1.owner, 2'b10);
    b1.dma_req = 0;
    repeat (2) @(negedge clk);
    chk("t3_cpu_not_yet", b1.cpu_gnt, 0);
    @(negedge clk);
    chk("t3_cpu_gnt", b1.cpu_gnt, 1);
    chk("t3_owner_cpu", b1.owner, 2'b01);
    chk("t3_addr_cpu", b1.mem_address, 12'o0200);
    b1.cpu_req = 0;
    repeat (4) @(negedge clk);
    // continuous DMA writes against a waiting CPU read
`ifdef ARB_STARVE_GUARD_EN
    cpu_k = 4;
`else
    cpu_k = 6;
`endif
    c = cyc;
    for (int k = 0; k <= 6; k++) begin
      if (k == cpu_k) sb.push_back('{0, 12'o7402, c + 3 + 3 * k});
      else if (k < 6) sb.push_back('{1, 12'o1234, c + 3 + 3 * k});
    end
    b1.dma_req = 1; b1.dma_we = 1; b1.dma_addr = 12'o0020; b1.dma_wdata = 12'o0555;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 12'o0200;
    for (int k = 0; k < 6; k++) begin
      while (cyc < c + 1 + 3 * k) @(negedge clk);
      chk($sformatf("t4_cpu_gnt_%0d", k), b1.cpu_gnt, k == cpu_k);
      chk($sformatf("t4_dma_gnt_%0d", k), b1.dma_gnt, k != cpu_k);
      if (b1.cpu_gnt) b1.cpu_req = 0;
    end
    b1.dma_req = 0;
    while (cyc < c + 19) @(negedge clk);
    chk("t4_cpu_gnt_6", b1.cpu_gnt, cpu_k == 6);
    b1.cpu_req = 0;
    while (cyc < c + 23) @(negedge clk);
    chk("t4_mem_written", mem1[12'o0020], 12'o0555);
    // MEM_LAT=3 read on the second instance
    c = cyc;
    sb.push_back('{2, 12'o5252, c + 5});
    b3.cpu_req = 1; b3.cpu_we = 0; b3.cpu_addr = 12'o0300;
    @(negedge clk);
    chk("t5_gnt", b3.cpu_gnt, 1);
    chk("t5_re", b3.mem_read_enable, 1);
    b3.cpu_req = 0;
    repeat (3) @(negedge clk);
    chk("t5_no_early_done", b3.cpu_done, 0);
    chk("t5_no_early_rdata", b3.cpu_rdata, 0);
    repeat (2) @(negedge clk);
    chk("t5_rdata_hold", b3.cpu_rdata, 12'o5252);
    // reset during WAIT abandons the access
    c = cyc;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 12'o0200;
    @(negedge clk);
    chk("t6_gnt", b1.cpu_gnt, 1);
    b1.cpu_req = 0;
    @(negedge clk);
    rst = 1;
    #1;
    chk("t6_busy", b1.busy, 0);
    chk("t6_owner", b1.owner, 0);
    chk("t6_outs", {b1.cpu_gnt, b1.cpu_done, b1.mem_read_enable, b1.mem_write_enable}, 0);
    chk("t6_cpu_rdata", b1.cpu_rdata, 0);
    chk("t6_dma_rdata", b1.dma_rdata, 0);
    chk("t6_addr", b1.mem_address, 0);
    chk("t6_b3_rdata", b3.cpu_rdata, 0);
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    c = cyc;
    sb.push_back('{0, 12'o7402, c + 3});
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 12'o0200;
    @(negedge clk);
    chk("t6_fresh_gnt", b1.cpu_gnt, 1);
    chk("t6_fresh_re", b1.mem_read_enable, 1);
    b1.cpu_req = 0;
    repeat (3) @(negedge clk);
    chk("t6_fresh_rdata", b1.cpu_rdata, 12'o7402);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
